// File: rtl/da_adjust_pipe_pkg.sv
// Shared defaults and divider FSM encoding for the DAC-based distance compensation stage.
package da_adjust_pipe_pkg;
    localparam int DIST_W_DEF    = 18;
    localparam int DAC_IN_W_DEF  = 16;
    localparam int DAC_LSB_DEF   = 4;
    localparam int DAC_SEL_W_DEF = 8;
    localparam int DAC_W_DEF     = 10;
    localparam int K_NUMER_DEF   = 2400;
    localparam int K_W_DEF       = 8;
    localparam int SHIFT_DEF     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/da_gain_div.sv
// Iterative restoring divider producing k = K_NUMER / (max - min), saturated to K_W bits.
module da_gain_div
    import da_adjust_pipe_pkg::*;
#(
    parameter int DAC_W   = DAC_W_DEF,
    parameter int K_NUMER = K_NUMER_DEF,
    parameter int K_W     = K_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DAC_W-1:0] max_i,
    input  logic [DAC_W-1:0] min_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [K_W-1:0]   k_o,
    output div_state_e       state_o
);
    localparam int NB = $clog2(K_NUMER + 1);
    localparam int CW = $clog2(NB + 1);
    localparam logic [NB-1:0] NUMER = NB'(K_NUMER);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    localparam logic [31:0] K_MAX = 32'((1 << K_W) - 1);

    div_state_e       state_q;
    logic [DAC_W-1:0] base_q;
    logic [DAC_W-1:0] rem_q;
    logic [DAC_W-1:0] rem_d;
    logic [NB-1:0]    num_q;
    logic [CW-1:0]    cnt_q;
    logic [K_W-1:0]   k_q;
    logic             done_q;
    logic [DAC_W:0]   trial;
    logic             trial_ge;
    logic [K_W-1:0]   quot_sat;

    // num_q shifts numerator bits out of the top while quotient bits enter at the bottom
    always_comb begin
        trial    = {rem_q, num_q[NB-1]};
        trial_ge = (trial >= {1'b0, base_q});
        rem_d    = trial_ge ? DAC_W'(trial - {1'b0, base_q}) : DAC_W'(trial);
        quot_sat = (32'(num_q) > K_MAX) ? '1 : K_W'(num_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (max_i > min_i) begin
                            base_q  <= max_i - min_i;
                            num_q   <= NUMER;
                            state_q <= ST_DIV;
                        end else begin
                            num_q   <= '0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    num_q <= {num_q[NB-2:0], trial_ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    k_q     <= quot_sat;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign k_o     = k_q;
    assign state_o = state_q;
endmodule

// File: rtl/da_adjust_pipe.sv
// Three-stage distance compensation: result = ad_distance - ((clamped dac offset * k) >> SHIFT).
module da_adjust_pipe
    import da_adjust_pipe_pkg::*;
#(
    parameter int DIST_W    = DIST_W_DEF,
    parameter int DAC_IN_W  = DAC_IN_W_DEF,
    parameter int DAC_LSB   = DAC_LSB_DEF,
    parameter int DAC_SEL_W = DAC_SEL_W_DEF,
    parameter int DAC_W     = DAC_W_DEF,
    parameter int K_NUMER   = K_NUMER_DEF,
    parameter int K_W       = K_W_DEF,
    parameter int SHIFT     = SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DAC_IN_W-1:0] dac_value,
    input  logic                temp_en,
    input  logic [DIST_W-1:0]   ad_distance,
    input  logic [DAC_W-1:0]    dac_max,
    input  logic [DAC_W-1:0]    dac_min,
    input  logic                cfg_load,
    input  logic                comp_en,
    output logic                k_busy,
    output logic                k_ready,
    output logic [K_W-1:0]      k_active,
    output logic                da_en,
    output logic [DIST_W-1:0]   da_distance,
    output logic                sat_flag
);
    localparam int PROD_W = DAC_W + K_W;
    localparam int CMP_W  = (DIST_W > PROD_W) ? DIST_W : PROD_W;

    div_state_e       div_state;
    logic             div_start;
    logic [DAC_W-1:0] min_q, base_q;
    logic [DAC_W-1:0] dac_real, change_d;
    logic             dac_unused;

    logic              s1_valid_q, s1_comp_q;
    logic [DAC_W-1:0]  s1_change_q;
    logic [K_W-1:0]    s1_k_q;
    logic [DIST_W-1:0] s1_dist_q;
    logic [PROD_W-1:0] corr_d;

    logic              s2_valid_q, s2_comp_q;
    logic [PROD_W-1:0] s2_corr_q;
    logic [DIST_W-1:0] s2_dist_q;
    logic [CMP_W-1:0]  corr_ext, dist_ext;
    logic [DIST_W-1:0] result_d;
    logic              sat_d;

    logic              da_en_q, sat_q;
    logic [DIST_W-1:0] da_dist_q;

    // k_active only changes when the divider finishes, so in-flight samples never see a partial k
    assign div_start = cfg_load & ~k_busy;

    da_gain_div #(
        .DAC_W  (DAC_W),
        .K_NUMER(K_NUMER),
        .K_W    (K_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .start_i(div_start),
        .max_i  (dac_max),
        .min_i  (dac_min),
        .busy_o (k_busy),
        .done_o (k_ready),
        .k_o    (k_active),
        .state_o(div_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q  <= '0;
            base_q <= '0;
        end else if (div_start) begin
            min_q  <= dac_min;
            base_q <= (dac_max > dac_min) ? dac_max - dac_min : '0;
        end
    end

    assign dac_real   = DAC_W'(dac_value[DAC_LSB+DAC_SEL_W-1:DAC_LSB]);
    assign dac_unused = ^{dac_value[DAC_IN_W-1:DAC_LSB+DAC_SEL_W], dac_value[DAC_LSB-1:0]};

    always_comb begin
        change_d = '0;
        if (dac_real > min_q) begin
            change_d = dac_real - min_q;
            if (change_d > base_q) change_d = base_q;
        end
    end

    assign corr_d = (PROD_W'(s1_change_q) * PROD_W'(s1_k_q)) >> SHIFT;

    always_comb begin
        corr_ext = CMP_W'(s2_corr_q);
        dist_ext = CMP_W'(s2_dist_q);
        result_d = s2_dist_q;
        sat_d    = 1'b0;
        if (s2_comp_q) begin
            if (corr_ext > dist_ext) begin
                result_d = '0;
                sat_d    = 1'b1;
            end else begin
                result_d = DIST_W'(dist_ext - corr_ext);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_comp_q   <= 1'b0;
            s1_change_q <= '0;
            s1_k_q      <= '0;
            s1_dist_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_comp_q   <= 1'b0;
            s2_corr_q   <= '0;
            s2_dist_q   <= '0;
            da_en_q     <= 1'b0;
            da_dist_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            s1_valid_q <= temp_en;
            if (temp_en) begin
                s1_change_q <= change_d;
                s1_k_q      <= k_active;
                s1_dist_q   <= ad_distance;
                s1_comp_q   <= comp_en;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_corr_q <= corr_d;
                s2_dist_q <= s1_dist_q;
                s2_comp_q <= s1_comp_q;
            end
            da_en_q <= s2_valid_q;
            if (s2_valid_q) begin
                da_dist_q <= result_d;
                sat_q     <= sat_d;
            end
        end
    end

    assign da_en       = da_en_q;
    assign da_distance = da_dist_q;
    assign sat_flag    = sat_q;
endmodule

// File: tb/tb_da_adjust_pipe.sv
// Bench for da_adjust_pipe: table vectors, hand sequences and random traffic against a reference model.
module tb_da_adjust_pipe;
    localparam int NB = $clog2(2400 + 1);

    logic        clk;
    logic        rst;
    logic [15:0] dac_value;
    logic        temp_en;
    logic [17:0] ad_distance;
    logic [9:0]  dac_max;
    logic [9:0]  dac_min;
    logic        cfg_load;
    logic        comp_en;
    logic        k_busy;
    logic        k_ready;
    logic [7:0]  k_active;
    logic        da_en;
    logic [17:0] da_distance;
    logic        sat_flag;

    da_adjust_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .dac_value  (dac_value),
        .temp_en    (temp_en),
        .ad_distance(ad_distance),
        .dac_max    (dac_max),
        .dac_min    (dac_min),
        .cfg_load   (cfg_load),
        .comp_en    (comp_en),
        .k_busy     (k_busy),
        .k_ready    (k_ready),
        .k_active   (k_active),
        .da_en      (da_en),
        .da_distance(da_distance),
        .sat_flag   (sat_flag)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    // reference configuration timeline: old values until the load/apply cycle, new values after
    int cfg_c = -1000, cfg_l = 2;
    int k_old = 0, k_new = 0, min_old = 0, min_new = 0, max_old = 0, max_new = 0;

    logic [18:0] exp_q[$];
    int          stamp_q[$];

    function automatic int k_at(int c);
        return (c >= cfg_c + cfg_l) ? k_new : k_old;
    endfunction
    function automatic int min_at(int c);
        return (c > cfg_c) ? min_new : min_old;
    endfunction
    function automatic int max_at(int c);
        return (c > cfg_c) ? max_new : max_old;
    endfunction
    function automatic bit busy_at(int c);
        return (c > cfg_c) && (c < cfg_c + cfg_l);
    endfunction
    function automatic int model_k(int mn, int mx);
        int q;
        if (mx <= mn) return 0;
        q = 2400 / (mx - mn);
        return (q > 255) ? 255 : q;
    endfunction
    function automatic logic [18:0] model_out(int dv, int ad, bit ce, int mn, int mx, int k);
        int real_v, base, ch, corr;
        real_v = (dv / 16) % 256;
        base   = (mx > mn) ? mx - mn : 0;
        ch     = real_v - mn;
        if (ch < 0) ch = 0;
        if (ch > base) ch = base;
        corr = (ch * k) / 32;
        if (!ce) return {1'b0, 18'(ad)};
        if (corr > ad) return {1'b1, 18'd0};
        return {1'b0, 18'(ad - corr)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // driver: one cycle of inputs, model updated for whatever the DUT will accept at the next edge
    task automatic drive_cycle(input bit te, input int dv, input int ad, input bit ce,
                               input bit cl, input int cmin, input int cmax,
                               input bit use_tab, input logic [18:0] tab_exp);
        int s;
        s = cyc;
        temp_en     = te;
        dac_value   = 16'(dv);
        ad_distance = 18'(ad);
        comp_en     = ce;
        cfg_load    = cl;
        dac_min     = 10'(cmin);
        dac_max     = 10'(cmax);
        if (te) begin
            exp_q.push_back(use_tab ? tab_exp : model_out(dv, ad, ce, min_at(s), max_at(s), k_at(s)));
            stamp_q.push_back(s);
        end
        if (cl && !busy_at(s)) begin
            k_old   = k_at(s);
            min_old = min_at(s);
            max_old = max_at(s);
            min_new = cmin;
            max_new = cmax;
            k_new   = model_k(cmin, cmax);
            cfg_c   = s;
            cfg_l   = (cmax > cmin) ? NB + 2 : 2;
        end
        @(posedge clk);
        #1;
        temp_en  = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 1, 0, 0, 0, 0, '0);
    endtask
    task automatic send(input int dv, input int ad, input bit ce);
        drive_cycle(1, dv, ad, ce, 0, 0, 0, 0, '0);
    endtask
    task automatic send_exp(input int dv, input int ad, input bit ce, input int ed, input bit es);
        drive_cycle(1, dv, ad, ce, 0, 0, 0, 1, {es, 18'(ed)});
    endtask
    task automatic cfg(input int mn, input int mx);
        drive_cycle(0, 0, 0, 1, 1, mn, mx, 0, '0);
    endtask
    task automatic model_reset();
        exp_q.delete();
        stamp_q.delete();
        cfg_c = -1000; cfg_l = 2;
        k_old = 0; k_new = 0; min_old = 0; min_new = 0; max_old = 0; max_new = 0;
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_da_en"}, da_en, 0);
        check({tag, "_da_distance"}, da_distance, 0);
        check({tag, "_sat_flag"}, sat_flag, 0);
        check({tag, "_k_active"}, k_active, 0);
        check({tag, "_k_busy"}, k_busy, 0);
        check({tag, "_k_ready"}, k_ready, 0);
    endtask

    // scoreboard / per-cycle monitor on the opposite edge
    always @(negedge clk) begin
        if (rst) begin
            logic [18:0] e;
            int          st;
            check("k_active", k_active, k_at(cyc));
            check("k_ready", k_ready, int'(cyc == cfg_c + cfg_l));
            check("k_busy", k_busy, int'(busy_at(cyc)));
            if (da_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_da_en", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    st = stamp_q.pop_front();
                    check("da_distance", da_distance, e[17:0]);
                    check("sat_flag", sat_flag, e[18]);
                    check("latency", cyc - st, 3);
                end
            end else if (stamp_q.size() > 0 && cyc >= stamp_q[0] + 3) begin
                check("lost_da_en", 0, 1);
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
        end
    end

    typedef struct {
        int dv;
        int ad;
        bit ce;
        int ed;
        bit es;
    } vec_t;
    vec_t tab[8];

    initial begin
        tab[0] = '{16'h0640, 1000, 1'b1, 975, 1'b0};   // linear: change 50, corr 25
        tab[1] = '{16'h0FA0, 1000, 1'b1, 925, 1'b0};   // dac_real 250 clamps to 150
        tab[2] = '{16'h0140, 1000, 1'b1, 1000, 1'b0};  // dac_real 20 clamps to 0
        tab[3] = '{16'h0640, 10, 1'b1, 0, 1'b1};       // underflow
        tab[4] = '{16'h0640, 1000, 1'b0, 1000, 1'b0};  // bypass
        tab[5] = '{16'hF64F, 1000, 1'b1, 975, 1'b0};   // unused dac bits ignored
        tab[6] = '{16'h0640, 25, 1'b1, 0, 1'b0};       // corr == distance, no clamp
        tab[7] = '{16'h0C80, 1000, 1'b1, 925, 1'b0};   // dac_real == max

        // clock / reset block
        rst = 1'b0; temp_en = 0; cfg_load = 0; comp_en = 1;
        dac_value = '0; ad_distance = '0; dac_min = '0; dac_max = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // linear configuration and table vectors
        cfg(50, 200);
        idle(NB + 2);
        check("k_after_cfg_50_200", k_active, 16);
        foreach (tab[i]) send_exp(tab[i].dv, tab[i].ad, tab[i].ce, tab[i].ed, tab[i].es);
        idle(5);

        // reconfigure mid-stream with continuous samples; second load during busy is ignored
        for (int i = 0; i < 30; i++) begin
            if (i == 3)
                drive_cycle(1, $urandom_range(50, 200) << 4, $urandom_range(1000, 5000), 1, 1, 50, 350, 0, '0);
            else if (i == 8)
                drive_cycle(1, $urandom_range(50, 200) << 4, $urandom_range(1000, 5000), 1, 1, 0, 5, 0, '0);
            else
                send($urandom_range(50, 200) << 4, $urandom_range(1000, 5000), 1);
        end
        idle(5);
        check("k_after_midstream", k_active, 8);

        // degenerate gains
        cfg(80, 80);
        idle(4);
        check("k_equal_minmax", k_active, 0);
        send_exp(16'h0640, 777, 1, 777, 0);
        idle(4);
        cfg(0, 5);
        idle(NB + 2);
        check("k_saturated", k_active, 255);
        send_exp(16'h0010, 100, 1, 93, 0);
        send_exp(16'h0030, 20, 1, 0, 1);
        idle(5);

        // reset in the middle of a division and of a busy pipeline
        cfg(50, 350);
        for (int i = 0; i < 6; i++) send(16'h0640, 2000, 1);
        check("pre_reset_busy", k_busy, 1);
        check("pre_reset_da_en", da_en, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_exp(16'h0640, 1234, 1, 1234, 0);
        idle(4);

        // randomized traffic with occasional reconfiguration
        for (int i = 0; i < 800; i++) begin
            bit te, ce, cl;
            int ad;
            te = ($urandom_range(0, 3) != 0);
            ce = ($urandom_range(0, 7) != 0);
            cl = ($urandom_range(0, 39) == 0);
            ad = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 100) : int'($urandom & 32'h3FFFF);
            drive_cycle(te, int'($urandom & 32'hFFFF), ad, ce, cl,
                        $urandom_range(0, 255), $urandom_range(0, 1023), 0, '0);
        end

        idle(8);
        check("drain_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
